pipelined_shifter: RTL and testbench
====================================

Name: pipelined_shifter

Overview:
- Parametrised, pipelined successor to the ALU's combinational logical-right shifter.
- Supports SLL, SRL, SRA, ROL and ROR over WIDTH bits.
- One log-shifter mux level per pipeline stage, with valid/ready handshakes on input and output.
- Sits between the ALU operand latch and the result mux; the ALU can issue one shift per cycle.

Parameters:
- WIDTH, 32: data width; must be a power of two, 8..64.
- SHW, $clog2(WIDTH): localparam, shift-amount width and pipeline depth; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  operand set presented.
- in_ready  output  1  block accepts operands this cycle.
- dataA  input  WIDTH  value to shift.
- dataB  input  WIDTH  shift amount; only dataB[SHW-1:0] is used, upper bits ignored.
- Signal  input  6  operation code.
- out_valid  output  1  dataOut/out_err valid.
- out_ready  input  1  downstream accepts result.
- dataOut  output  WIDTH  shifted result.
- out_err  output  1  Signal was not a legal shift code.

Behaviour:
- Signal codes:
  - SLL 6'b000000
  - SRL 6'b000010 (matches existing ALU encoding)
  - SRA 6'b000011
  - ROL 6'b000100
  - ROR 6'b000110
  - Any other code: dataOut = 0 and out_err = 1 at the output; the transaction still flows through the pipeline normally.
- Reset (reset = 0, asynchronous):
  - All stage valid bits clear; out_valid = 0, dataOut = 0, out_err = 0.
  - Stage data registers clear to 0; in_ready = 1 as soon as reset is released.
- Pipeline structure:
  - SHW stages. Stage k (k = 0..SHW-1) conditionally shifts by 2^k, controlled by shift-amount bit k, and registers the result.
  - Each stage carries a valid bit, the data, the remaining shift-amount bits, the decoded op and the err bit.
- Latency and throughput:
  - Latency is exactly SHW cycles from the accept edge to out_valid = 1 with no back-pressure (WIDTH = 32 gives 5).
  - Throughput is 1 transaction per cycle.
- Per-stage fill rules:
  - SLL: fills 0 from the LSB.
  - SRL: fills 0 from the MSB.
  - SRA: fills with bit WIDTH-1 of the original dataA, carried through the stages as a sign bit.
  - ROL/ROR: rotate, with no fill.
- Handshake:
  - Input accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - Global stall: advance = !out_valid | out_ready; in_ready = advance.
  - When advance = 0, every stage register holds its value and no bubble collapses (simple stall-all pipeline).
  - While out_valid = 1 and out_ready = 0, dataOut and out_err are held stable.
- Bubbles: if in_valid = 0 on an advancing cycle, a bubble (valid 0) enters stage 0. Data registers of invalid stages may take any value, but out_valid must be 0.
- Boundary conditions:
  - Shift amount 0 returns dataA unchanged for every legal op.
  - Shift amount WIDTH-1 with SRL on all-ones gives 1; with SRA on all-ones gives all-ones.
  - Upper dataB bits beyond SHW never affect the result (no saturation to zero at amounts ≥ WIDTH).
- Simultaneous events: on the same edge, an output transfer and an input accept both occur when advance = 1; the pipeline shifts by one stage.
- Mid-operation reset: all in-flight transactions are discarded and nothing emerges after release.
- Ordering: results appear in input order; no reordering and no dropping, provided the handshakes are honoured.

Test Plan:
- Reset, then SRL with dataA = 32'h8000_0000, dataB = 31, out_ready = 1 -> out_valid rises exactly 5 cycles after accept; dataOut = 32'h0000_0001, out_err = 0.
- Back-to-back ops SLL(32'h0000_0001, 4), SRA(32'h8000_0000, 4), ROR(32'h0000_000F, 4), ROL(32'hF000_0000, 4) on consecutive cycles -> consecutive outputs 32'h0000_0010, 32'hF800_0000, 32'hF000_0000, 32'h0000_000F.
- Illegal Signal = 6'b111111 with dataA = 32'hFFFF_FFFF -> dataOut = 0 and out_err = 1 at latency 5; next legal op unaffected.
- Hold out_ready = 0 for 10 cycles with 7 inputs offered -> in_ready falls once the output is valid; exactly 5 accepted, dataOut stable; release -> all 5 emerge in order, then the remaining inputs are accepted.
- dataB = 32'hFFFF_FFE0 (low 5 bits 0) with SRL of 32'h1234_5678 -> dataOut = 32'h1234_5678.
- Assert reset with 3 transactions in flight, release -> out_valid = 0 immediately and stays 0 until a new accept plus 5 cycles; repeat the directed cases with WIDTH = 8 (latency 3, ROR(8'h01, 1) = 8'h80).

Source files
------------

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROL/ROR, one log-shifter level per registered stage,
// stall-all valid/ready handshake. Illegal op codes flow through as zero data with out_err set.

module pipelined_shifter_stage #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5,
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [SHW-1:0]   amt_i,
    input  logic [2:0]       ctl_i,
    input  logic             sign_i,
    input  logic             err_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] data_o,
    output logic [SHW-1:0]   amt_o,
    output logic [2:0]       ctl_o,
    output logic             sign_o,
    output logic             err_o
);
    localparam int SH = 1 << K;

    // ctl_i = {arith, rotate, left}
    logic [WIDTH-1:0] shl, shr, sra, rol, ror, nxt;

    assign shl = data_i << SH;
    assign shr = data_i >> SH;
    assign sra = shr | ({WIDTH{sign_i}} & ~({WIDTH{1'b1}} >> SH));
    assign rol = (data_i << SH) | (data_i >> (WIDTH - SH));
    assign ror = (data_i >> SH) | (data_i << (WIDTH - SH));

    always_comb begin
        nxt = data_i;
        if (amt_i[K]) begin
            if (ctl_i[1])      nxt = ctl_i[0] ? rol : ror;
            else if (ctl_i[0]) nxt = shl;
            else if (ctl_i[2]) nxt = sra;
            else               nxt = shr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_o  <= 1'b0;
            data_o <= '0;
            amt_o  <= '0;
            ctl_o  <= '0;
            sign_o <= 1'b0;
            err_o  <= 1'b0;
        end else if (en) begin
            vld_o  <= vld_i;
            data_o <= nxt;
            amt_o  <= amt_i;
            ctl_o  <= ctl_i;
            sign_o <= sign_i;
            err_o  <= err_i;
        end
    end
endmodule

module pipelined_shifter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dataOut,
    output logic             out_err
);
    localparam int SHW = $clog2(WIDTH);

    logic [SHW:0]            vld_pipe;
    logic [SHW:0][WIDTH-1:0] data_pipe;
    logic [SHW:0][SHW-1:0]   amt_pipe;
    logic [SHW:0][2:0]       ctl_pipe;
    logic [SHW:0]            sign_pipe;
    logic [SHW:0]            err_pipe;
    logic                    advance;

    assign advance  = !out_valid | out_ready;
    assign in_ready = advance;

    // Illegal codes enter as an SRL of zero so the result is zero at every stage.
    always_comb begin
        data_pipe[0] = dataA;
        ctl_pipe[0]  = 3'b000;
        err_pipe[0]  = 1'b0;
        unique case (Signal)
            6'b000000: ctl_pipe[0] = 3'b001;
            6'b000010: ctl_pipe[0] = 3'b000;
            6'b000011: ctl_pipe[0] = 3'b100;
            6'b000100: ctl_pipe[0] = 3'b011;
            6'b000110: ctl_pipe[0] = 3'b010;
            default: begin
                err_pipe[0]  = 1'b1;
                data_pipe[0] = '0;
            end
        endcase
    end

    assign vld_pipe[0]  = in_valid;
    assign amt_pipe[0]  = dataB[SHW-1:0];
    assign sign_pipe[0] = dataA[WIDTH-1];

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        pipelined_shifter_stage #(.WIDTH(WIDTH), .SHW(SHW), .K(k)) u_stage (
            .clk    (clk),
            .reset  (reset),
            .en     (advance),
            .vld_i  (vld_pipe[k]),
            .data_i (data_pipe[k]),
            .amt_i  (amt_pipe[k]),
            .ctl_i  (ctl_pipe[k]),
            .sign_i (sign_pipe[k]),
            .err_i  (err_pipe[k]),
            .vld_o  (vld_pipe[k+1]),
            .data_o (data_pipe[k+1]),
            .amt_o  (amt_pipe[k+1]),
            .ctl_o  (ctl_pipe[k+1]),
            .sign_o (sign_pipe[k+1]),
            .err_o  (err_pipe[k+1])
        );
    end

    assign out_valid = vld_pipe[SHW];
    assign dataOut   = data_pipe[SHW];
    assign out_err   = err_pipe[SHW];

    logic unused_bits;
    assign unused_bits = ^{dataB[WIDTH-1:SHW], amt_pipe[SHW], ctl_pipe[SHW], sign_pipe[SHW]};
endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboarded bench for pipelined_shifter at WIDTH=32 and WIDTH=8.
module tb_pipelined_shifter;
    localparam logic [5:0] SLL = 6'b000000, SRL = 6'b000010, SRA = 6'b000011,
                           ROL = 6'b000100, ROR = 6'b000110, BAD = 6'b111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        in_valid, in_ready, out_valid, out_ready, out_err;
    logic [31:0] dataA, dataB, dataOut;
    logic [5:0]  sig;
    logic        in_valid8, in_ready8, out_valid8, out_ready8, out_err8;
    logic [7:0]  dataA8, dataB8, dataOut8;
    logic [5:0]  sig8;

    pipelined_shifter #(.WIDTH(32)) dut (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dataA(dataA), .dataB(dataB), .Signal(sig), .out_valid(out_valid),
        .out_ready(out_ready), .dataOut(dataOut), .out_err(out_err));

    pipelined_shifter #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .dataA(dataA8), .dataB(dataB8), .Signal(sig8), .out_valid(out_valid8),
        .out_ready(out_ready8), .dataOut(dataOut8), .out_err(out_err8));

    int checks = 0;
    int errors = 0;
    logic [64:0] sb32[$];
    logic [64:0] sb8[$];
    logic [64:0] exp32, exp8;

    // Bit-by-bit reference: result bit i picks its source bit directly.
    function automatic logic [64:0] model(input int w, input logic [5:0] op,
                                          input logic [63:0] a, input logic [63:0] b);
        int n, s;
        logic [63:0] r;
        logic e;
        n = int'(b[5:0]) % w;
        r = '0;
        e = 1'b0;
        for (int i = 0; i < w; i++) begin
            case (op)
                SLL: begin s = i - n; if (s >= 0) r[i] = a[s]; end
                SRL: begin s = i + n; if (s < w) r[i] = a[s]; end
                SRA: begin s = i + n; if (s < w) r[i] = a[s]; else r[i] = a[w-1]; end
                ROL: r[i] = a[(i - n + w) % w];
                ROR: r[i] = a[(i + n) % w];
                default: e = 1'b1;
            endcase
        end
        return {e, r};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            sb32.delete();
            sb8.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb32.size() == 0) begin
                    errors++;
                    $display("FAIL sb32_unexpected: got data=%h err=%b with empty scoreboard", dataOut, out_err);
                end else begin
                    exp32 = sb32.pop_front();
                    if ({out_err, dataOut} !== {exp32[64], exp32[31:0]}) begin
                        errors++;
                        $display("FAIL sb32_result: got data=%h err=%b, expected data=%h err=%b",
                                 dataOut, out_err, exp32[31:0], exp32[64]);
                    end
                end
            end
            if (out_valid8 && out_ready8) begin
                checks++;
                if (sb8.size() == 0) begin
                    errors++;
                    $display("FAIL sb8_unexpected: got data=%h err=%b with empty scoreboard", dataOut8, out_err8);
                end else begin
                    exp8 = sb8.pop_front();
                    if ({out_err8, dataOut8} !== {exp8[64], exp8[7:0]}) begin
                        errors++;
                        $display("FAIL sb8_result: got data=%h err=%b, expected data=%h err=%b",
                                 dataOut8, out_err8, exp8[7:0], exp8[64]);
                    end
                end
            end
            if (in_valid && in_ready)
                sb32.push_back(model(32, sig, {32'b0, dataA}, {32'b0, dataB}));
            if (in_valid8 && in_ready8)
                sb8.push_back(model(8, sig8, {56'b0, dataA8}, {56'b0, dataB8}));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        repeat (n) tick();
    endtask

    task automatic send32(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        logic acc;
        sig = op; dataA = a; dataB = b; in_valid = 1'b1; n = 0;
        do begin
            acc = in_ready;
            tick();
            n++;
        end while (!acc && n < 100);
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send32_timeout: got no accept, expected accept within 100 cycles");
        end
    endtask

    task automatic send8(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        int n;
        logic acc;
        sig8 = op; dataA8 = a; dataB8 = b; in_valid8 = 1'b1; n = 0;
        do begin
            acc = in_ready8;
            tick();
            n++;
        end while (!acc && n < 100);
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send8_timeout: got no accept, expected accept within 100 cycles");
        end
    endtask

    // Presents one op and returns cycles from accept edge (counted as 1) to out_valid.
    task automatic measure32(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                             output int lat);
        sig = op; dataA = a; dataB = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        #12;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
        if (dataOut !== 32'h0) begin errors++; $display("FAIL reset_dataOut: got %h, expected 0", dataOut); end
        if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err: got %b, expected 0", out_err); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        checks += 2;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
        if (in_ready8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready8: got %b, expected 1", in_ready8); end
    endtask

    task automatic test_latency();
        int lat;
        measure32(SRL, 32'h8000_0000, 32'd31, lat);
        checks += 2;
        if (lat != 5) begin errors++; $display("FAIL latency32: got %0d cycles, expected 5", lat); end
        if ({out_err, dataOut} !== {1'b0, 32'h0000_0001}) begin
            errors++; $display("FAIL latency32_data: got %h err=%b, expected 00000001 err=0", dataOut, out_err);
        end
        drain(3);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [4] = '{32'h0000_0010, 32'hF800_0000, 32'hF000_0000, 32'h0000_000F};
        logic [31:0] got [4];
        int cyc [4];
        int cnt = 0;
        send32(SLL, 32'h0000_0001, 32'd4);
        send32(SRA, 32'h8000_0000, 32'd4);
        send32(ROR, 32'h0000_000F, 32'd4);
        send32(ROL, 32'hF000_0000, 32'd4);
        in_valid = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (out_valid && cnt < 4) begin
                got[cnt] = dataOut; cyc[cnt] = c; cnt++;
            end
            tick();
        end
        checks++;
        if (cnt != 4) begin errors++; $display("FAIL b2b_count: got %0d outputs, expected 4", cnt); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== exp[i]) begin
                    errors++; $display("FAIL b2b_data%0d: got %h, expected %h", i, got[i], exp[i]);
                end
            end
            checks++;
            if (cyc[3] - cyc[0] != 3) begin
                errors++; $display("FAIL b2b_consecutive: got span %0d, expected 3", cyc[3] - cyc[0]);
            end
        end
    endtask

    task automatic test_illegal();
        int n = 0;
        send32(BAD, 32'hFFFF_FFFF, 32'd5);
        send32(SLL, 32'h0000_0003, 32'd2);
        in_valid = 1'b0;
        while (!out_valid && n < 20) begin tick(); n++; end
        checks += 2;
        if ({out_err, dataOut} !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL illegal_result: got %h err=%b, expected 00000000 err=1", dataOut, out_err);
        end
        tick();
        if ({out_valid, out_err, dataOut} !== {2'b10, 32'h0000_000C}) begin
            errors++; $display("FAIL illegal_next: got v=%b %h err=%b, expected v=1 0000000c err=0",
                               out_valid, dataOut, out_err);
        end
        drain(6);
    endtask

    task automatic test_boundary();
        send32(SRL, 32'hFFFF_FFFF, 32'd31);
        send32(SRA, 32'hFFFF_FFFF, 32'd31);
        send32(SLL, 32'hA5C3_0F96, 32'd0);
        send32(SRL, 32'hA5C3_0F96, 32'd0);
        send32(SRA, 32'hA5C3_0F96, 32'd0);
        send32(ROL, 32'hA5C3_0F96, 32'd0);
        send32(ROR, 32'hA5C3_0F96, 32'd0);
        send32(SRA, 32'h7FFF_0000, 32'd31);
        in_valid = 1'b0;
        drain(8);
    endtask

    task automatic test_upper_bits();
        int lat;
        measure32(SRL, 32'h1234_5678, 32'hFFFF_FFE0, lat);
        checks++;
        if (dataOut !== 32'h1234_5678) begin
            errors++; $display("FAIL upper_bits: got %h, expected 12345678", dataOut);
        end
        drain(3);
    endtask

    task automatic test_stall();
        logic [31:0] vals [7] = '{32'h0000_0001, 32'h8000_0001, 32'h1234_5678, 32'hDEAD_BEEF,
                                  32'h0F0F_0F0F, 32'hCAFE_F00D, 32'h0000_8000};
        int idx = 0;
        int n = 0;
        logic acc, have, stable, rdy_bad;
        logic [32:0] held;
        have = 1'b0; stable = 1'b1; rdy_bad = 1'b0; held = '0;
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (idx < 7) begin in_valid = 1'b1; sig = ROL; dataA = vals[idx]; dataB = idx + 1; end
            else in_valid = 1'b0;
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
            if (out_valid) begin
                if (!have) begin held = {out_err, dataOut}; have = 1'b1; end
                else if ({out_err, dataOut} !== held) stable = 1'b0;
                if (in_ready) rdy_bad = 1'b1;
            end
        end
        checks += 4;
        if (idx != 5) begin errors++; $display("FAIL stall_accepted: got %0d, expected 5", idx); end
        if (!have) begin errors++; $display("FAIL stall_out_valid: got no valid output, expected valid"); end
        if (!stable) begin errors++; $display("FAIL stall_hold: got changing dataOut, expected stable"); end
        if (rdy_bad) begin errors++; $display("FAIL stall_in_ready: got 1 while stalled, expected 0"); end
        out_ready = 1'b1;
        while (idx < 7 && n < 50) begin
            in_valid = 1'b1; sig = ROL; dataA = vals[idx]; dataB = idx + 1;
            acc = in_ready;
            tick();
            if (acc) idx++;
            n++;
        end
        in_valid = 1'b0;
        checks++;
        if (idx != 7) begin errors++; $display("FAIL stall_release: got %0d accepted, expected 7", idx); end
        drain(8);
    endtask

    task automatic test_random();
        logic [5:0] ops [6] = '{SLL, SRL, SRA, ROL, ROR, 6'b010101};
        for (int c = 0; c < 120; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            sig   = ops[$urandom_range(0, 5)];
            dataA = $urandom;
            dataB = $urandom;
            out_ready8 = ($urandom_range(0, 2) != 0);
            in_valid8  = ($urandom_range(0, 1) != 0);
            sig8   = ops[$urandom_range(0, 5)];
            dataA8 = 8'($urandom);
            dataB8 = 8'($urandom);
            tick();
        end
        in_valid = 1'b0; in_valid8 = 1'b0; out_ready = 1'b1; out_ready8 = 1'b1;
        drain(8);
    endtask

    task automatic test_midreset();
        int lat;
        logic leak = 1'b0;
        send32(SLL, 32'h0000_0001, 32'd1);
        send32(SRL, 32'h0000_0100, 32'd1);
        send32(ROR, 32'h0000_0001, 32'd1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_now: got out_valid %b, expected 0", out_valid); end
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) leak = 1'b1;
            tick();
        end
        checks++;
        if (leak) begin errors++; $display("FAIL midreset_leak: got out_valid 1 after reset, expected 0"); end
        measure32(ROR, 32'h0000_0001, 32'd1, lat);
        checks += 2;
        if (lat != 5) begin errors++; $display("FAIL midreset_latency: got %0d, expected 5", lat); end
        if (dataOut !== 32'h8000_0000) begin errors++; $display("FAIL midreset_data: got %h, expected 80000000", dataOut); end
        drain(3);
    endtask

    task automatic test_w8();
        int lat;
        sig8 = ROR; dataA8 = 8'h01; dataB8 = 8'h01; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 20) begin tick(); lat++; end
        checks += 2;
        if (lat != 3) begin errors++; $display("FAIL w8_latency: got %0d, expected 3", lat); end
        if (dataOut8 !== 8'h80) begin errors++; $display("FAIL w8_ror: got %h, expected 80", dataOut8); end
        drain(2);
        send8(SRL, 8'hFF, 8'd7);
        send8(SRA, 8'hFF, 8'd7);
        send8(SLL, 8'h5A, 8'd0);
        send8(SRL, 8'h5A, 8'd0);
        send8(SRA, 8'hA5, 8'd0);
        send8(ROL, 8'h5A, 8'd0);
        send8(ROR, 8'h5A, 8'd0);
        send8(SRL, 8'h34, 8'hF8);
        send8(SLL, 8'h01, 8'd4);
        send8(SRA, 8'h80, 8'd4);
        send8(BAD, 8'hFF, 8'd1);
        send8(ROL, 8'h81, 8'd1);
        in_valid8 = 1'b0;
        drain(6);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; dataA = '0; dataB = '0; sig = SLL; out_ready = 1'b1;
        in_valid8 = 1'b0; dataA8 = '0; dataB8 = '0; sig8 = SLL; out_ready8 = 1'b1;
        test_reset();
        test_latency();
        test_back_to_back();
        test_illegal();
        test_boundary();
        test_upper_bits();
        test_stall();
        test_random();
        test_midreset();
        test_w8();
        drain(4);
        checks += 2;
        if (sb32.size() != 0) begin errors++; $display("FAIL sb32_drain: got %0d pending, expected 0", sb32.size()); end
        if (sb8.size() != 0) begin errors++; $display("FAIL sb8_drain: got %0d pending, expected 0", sb8.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish within 200000 time units");
        $fatal(1, "watchdog");
    end
endmodule
